// File: rtl/commit_trace_buffer_pkg.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buffer_pkg
// Description : Shared types for the commit trace buffer. Holds the basic
//               machine types, the per-entry commit record and the default
//               commit width.
// Ports       : none (package)
// Revision    : 1.0 - initial multi-commit trace buffer definitions
// ============================================================================
package commit_trace_buffer_pkg;

  typedef logic [31:0] addr_t;
  typedef logic [31:0] word_t;
  typedef logic [4:0]  regidx_t;
  typedef logic [3:0]  strobe_t;

  localparam regidx_t R0 = 5'd0;

  // Default number of commit lanes per cycle.
  localparam int NUM_COMMIT_DEFAULT = 2;

  // One queued trace record. wen is 0 for writes to the zero register.
  typedef struct packed {
    addr_t   pc;
    regidx_t id;
    word_t   data;
    logic    wen;
  } commit_t;

  // Expand the stored single-bit write flag onto the byte-strobe trace port.
  function automatic strobe_t wen_strobe(input logic wen);
    return {4{wen}};
  endfunction

endpackage
`default_nettype wire

// File: rtl/commit_trace_buffer_compactor.sv
`default_nettype none
// ============================================================================
// Module      : commit_compactor
// Description : Packs the qualified commit lanes into consecutive slots in
//               lane order (lane 0 first) and reports how many were packed.
// Ports       : eff_valid_i - qualified per-lane strobe
//               pc_i/id_i/data_i - flattened per-lane payloads
//               slot_o      - compacted records, slot 0 is oldest
//               push_cnt_o  - number of valid slots
// Revision    : 1.0 - initial
// ============================================================================
module commit_compactor
  import commit_trace_buffer_pkg::*;
#(
  parameter  int NUM_COMMIT = NUM_COMMIT_DEFAULT,
  localparam int PCNT_W     = $clog2(NUM_COMMIT + 1)
) (
  input  logic [NUM_COMMIT-1:0]    eff_valid_i,
  input  logic [NUM_COMMIT*32-1:0] pc_i,
  input  logic [NUM_COMMIT*5-1:0]  id_i,
  input  logic [NUM_COMMIT*32-1:0] data_i,
  output commit_t [NUM_COMMIT-1:0] slot_o,
  output logic [PCNT_W-1:0]        push_cnt_o
);

  // Lane i lands in slot j when it is valid and exactly j valid lanes
  // precede it. The running count is the prefix popcount.
  always_comb begin
    int unsigned run;
    run        = 0;
    slot_o     = '0;
    push_cnt_o = '0;
    for (int i = 0; i < NUM_COMMIT; i++) begin
      for (int j = 0; j < NUM_COMMIT; j++) begin
        if (eff_valid_i[i] && (run == j)) begin
          slot_o[j].pc   = pc_i[i*32 +: 32];
          slot_o[j].id   = id_i[i*5 +: 5];
          slot_o[j].data = data_i[i*32 +: 32];
          slot_o[j].wen  = (id_i[i*5 +: 5] != R0);
        end
      end
      if (eff_valid_i[i]) begin
        run = run + 1;
      end
    end
    push_cnt_o = PCNT_W'(run);
  end

endmodule
`default_nettype wire

// File: rtl/commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : commit_trace_buffer
// Description : Multi-commit golden-trace buffer. Accepts up to NUM_COMMIT
//               retired instructions per cycle, queues them in program order
//               and drains one per cycle onto the debug_wb_* trace port.
// Ports       : clk, reset (sync, active high)
//               commit_valid/pc/id/data - flattened per-lane commit inputs
//               ready    - room for a full NUM_COMMIT group
//               level    - current occupancy
//               overflow - sticky, a valid commit was dropped
//               debug_wb_pc/rf_wen/rf_wnum/rf_wdata - registered trace output
// Revision    : 1.0 - initial
// ============================================================================
module commit_trace_buffer
  import commit_trace_buffer_pkg::*;
#(
  parameter  int NUM_COMMIT = NUM_COMMIT_DEFAULT,
  parameter  int DEPTH      = 8,
  parameter  bit FILTER_R0  = 1'b1,
  localparam int LEVEL_W    = $clog2(DEPTH + 1)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_COMMIT-1:0]    commit_valid,
  input  logic [NUM_COMMIT*32-1:0] commit_pc,
  input  logic [NUM_COMMIT*5-1:0]  commit_id,
  input  logic [NUM_COMMIT*32-1:0] commit_data,
  output logic                     ready,
  output logic [LEVEL_W-1:0]       level,
  output logic                     overflow,
  output logic [31:0]              debug_wb_pc,
  output logic [3:0]               debug_wb_rf_wen,
  output logic [4:0]               debug_wb_rf_wnum,
  output logic [31:0]              debug_wb_rf_wdata
);

  localparam int PTR_W  = $clog2(DEPTH);
  localparam int PCNT_W = $clog2(NUM_COMMIT + 1);

  // Pointers are log2(DEPTH) wide, so DEPTH must be a power of two >= 2.
  if (!((DEPTH >= 2) && ((DEPTH & (DEPTH - 1)) == 0) && (DEPTH >= NUM_COMMIT)))
  begin : g_bad_params
    $error("commit_trace_buffer: DEPTH must be a power of two >= max(2, NUM_COMMIT)");
  end

  // --------------------------------------------------------------------------
  // Lane qualification and compaction
  // --------------------------------------------------------------------------
  logic [NUM_COMMIT-1:0] eff_valid;

  for (genvar gi = 0; gi < NUM_COMMIT; gi++) begin : g_lane
    assign eff_valid[gi] = commit_valid[gi] &&
                           !(FILTER_R0 && (commit_id[gi*5 +: 5] == R0));
  end

  commit_t [NUM_COMMIT-1:0] slot;
  logic [PCNT_W-1:0]        push_cnt;

  commit_compactor #(
    .NUM_COMMIT (NUM_COMMIT)
  ) u_compactor (
    .eff_valid_i (eff_valid),
    .pc_i        (commit_pc),
    .id_i        (commit_id),
    .data_i      (commit_data),
    .slot_o      (slot),
    .push_cnt_o  (push_cnt)
  );

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  commit_t            mem_q [DEPTH];
  logic [PTR_W-1:0]   head_q, head_d;
  logic [PTR_W-1:0]   tail_q, tail_d;
  logic [LEVEL_W-1:0] count_q, count_d;
  logic               overflow_q, overflow_d;
  logic [31:0]        dbg_pc_q, dbg_pc_d;
  logic [3:0]         dbg_wen_q, dbg_wen_d;
  logic [4:0]         dbg_wnum_q, dbg_wnum_d;
  logic [31:0]        dbg_wdata_q, dbg_wdata_d;

  logic ready_w, any_valid_w, push_w, drop_w, pop_w;

  // Ready looks only at the registered count; a same-cycle pop is not
  // credited, which keeps the check off the pop path.
  assign ready_w     = (LEVEL_W'(DEPTH) - count_q) >= LEVEL_W'(NUM_COMMIT);
  assign any_valid_w = |eff_valid;
  assign push_w      = ready_w && any_valid_w;
  assign drop_w      = !ready_w && any_valid_w;
  assign pop_w       = (count_q != '0);

  always_comb begin
    head_d      = head_q;
    tail_d      = tail_q;
    overflow_d  = overflow_q | drop_w;
    dbg_pc_d    = dbg_pc_q;
    dbg_wen_d   = '0;
    dbg_wnum_d  = dbg_wnum_q;
    dbg_wdata_d = dbg_wdata_q;
    count_d     = count_q + (push_w ? LEVEL_W'(push_cnt) : '0) - LEVEL_W'(pop_w);

    if (pop_w) begin
      head_d      = head_q + PTR_W'(1);
      dbg_pc_d    = mem_q[head_q].pc;
      dbg_wen_d   = wen_strobe(mem_q[head_q].wen);
      dbg_wnum_d  = mem_q[head_q].id;
      dbg_wdata_d = mem_q[head_q].data;
    end

    if (push_w) begin
      tail_d = tail_q + PTR_W'(push_cnt);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      head_q      <= '0;
      tail_q      <= '0;
      count_q     <= '0;
      overflow_q  <= 1'b0;
      dbg_pc_q    <= '0;
      dbg_wen_q   <= '0;
      dbg_wnum_q  <= '0;
      dbg_wdata_q <= '0;
    end else begin
      head_q      <= head_d;
      tail_q      <= tail_d;
      count_q     <= count_d;
      overflow_q  <= overflow_d;
      dbg_pc_q    <= dbg_pc_d;
      dbg_wen_q   <= dbg_wen_d;
      dbg_wnum_q  <= dbg_wnum_d;
      dbg_wdata_q <= dbg_wdata_d;
    end
  end

  // Storage carries no reset; count gates every read of it.
  always_ff @(posedge clk) begin
    if (!reset && push_w) begin
      for (int j = 0; j < NUM_COMMIT; j++) begin
        if (PCNT_W'(j) < push_cnt) begin
          mem_q[tail_q + PTR_W'(j)] <= slot[j];
        end
      end
    end
  end

  assign ready             = ready_w;
  assign level             = count_q;
  assign overflow          = overflow_q;
  assign debug_wb_pc       = dbg_pc_q;
  assign debug_wb_rf_wen   = dbg_wen_q;
  assign debug_wb_rf_wnum  = dbg_wnum_q;
  assign debug_wb_rf_wdata = dbg_wdata_q;

  // --------------------------------------------------------------------------
  // Invariants
  // --------------------------------------------------------------------------
  a_count_bound : assert property (@(posedge clk) disable iff (reset)
                                   count_q <= LEVEL_W'(DEPTH));
  a_no_pop_empty : assert property (@(posedge clk) disable iff (reset)
                                    (count_q == '0) |-> !pop_w);
  a_level_count : assert property (@(posedge clk) disable iff (reset)
                                   level == count_q);

endmodule
`default_nettype wire

// File: tb/tb_commit_trace_buffer.sv
`default_nettype none
// ============================================================================
// Module      : tb_commit_trace_buffer
// Description : Scoreboard bench for commit_trace_buffer. Two instances share
//               the commit inputs, one dropping R0 commits and one keeping
//               them. Accepted commits are queued as expected trace records
//               when driven and popped as the trace port drains.
// Revision    : 1.0 - initial
// ============================================================================
module tb_commit_trace_buffer;

  localparam int NC    = 2;
  localparam int DEPTH = 8;

  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  id;
    logic [31:0] data;
    logic        wen;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset = 1'b1;
  logic [NC-1:0]     cv    = '0;
  logic [NC*32-1:0]  cpc   = '0;
  logic [NC*5-1:0]   cid   = '0;
  logic [NC*32-1:0]  cdata = '0;

  logic        rdy   [2];
  logic        ovf   [2];
  logic [3:0]  lvl   [2];
  logic [31:0] wpc   [2];
  logic [3:0]  wen   [2];
  logic [4:0]  wnum  [2];
  logic [31:0] wdata [2];

  commit_trace_buffer #(.NUM_COMMIT(NC), .DEPTH(DEPTH), .FILTER_R0(1'b1)) u_dut_filt (
    .clk(clk), .reset(reset), .commit_valid(cv), .commit_pc(cpc), .commit_id(cid),
    .commit_data(cdata), .ready(rdy[0]), .level(lvl[0]), .overflow(ovf[0]),
    .debug_wb_pc(wpc[0]), .debug_wb_rf_wen(wen[0]), .debug_wb_rf_wnum(wnum[0]),
    .debug_wb_rf_wdata(wdata[0])
  );

  commit_trace_buffer #(.NUM_COMMIT(NC), .DEPTH(DEPTH), .FILTER_R0(1'b0)) u_dut_keep (
    .clk(clk), .reset(reset), .commit_valid(cv), .commit_pc(cpc), .commit_id(cid),
    .commit_data(cdata), .ready(rdy[1]), .level(lvl[1]), .overflow(ovf[1]),
    .debug_wb_pc(wpc[1]), .debug_wb_rf_wen(wen[1]), .debug_wb_rf_wnum(wnum[1]),
    .debug_wb_rf_wdata(wdata[1])
  );

  exp_t sb_filt[$];
  exp_t sb_keep[$];
  exp_t last_m [2];
  logic ovf_m  [2];
  bit   known = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int sb_size(input int k);
    return (k == 0) ? sb_filt.size() : sb_keep.size();
  endfunction

  task automatic sb_push(input int k, input exp_t e);
    if (k == 0) sb_filt.push_back(e);
    else        sb_keep.push_back(e);
  endtask

  task automatic sb_pop(input int k, output exp_t e);
    if (k == 0) e = sb_filt.pop_front();
    else        e = sb_keep.pop_front();
  endtask

  task automatic sb_clear(input int k);
    if (k == 0) sb_filt.delete();
    else        sb_keep.delete();
  endtask

  task automatic set_lane(input int l, input logic [31:0] p, input logic [4:0] i,
                          input logic [31:0] d);
    cv[l]            = 1'b1;
    cpc[l*32 +: 32]  = p;
    cid[l*5 +: 5]    = i;
    cdata[l*32 +: 32] = d;
  endtask

  task automatic idle();
    cv = '0;
  endtask

  // One clock: model the cycle from the inputs already driven, clock, then
  // compare the registered outputs of both instances.
  task automatic cycle();
    bit   pop_m [2];
    exp_t pe    [2];
    for (int k = 0; k < 2; k++) begin
      int   sz;
      bit   any;
      bit   filt;
      exp_t e;
      sz   = sb_size(k);
      any  = 1'b0;
      filt = (k == 0);
      if (known && !reset) begin
        chk($sformatf("ready[%0d]", k), 64'(rdy[k]), 64'((DEPTH - sz) >= NC));
        chk($sformatf("level[%0d]", k), 64'(lvl[k]), 64'(sz));
      end
      pop_m[k] = 1'b0;
      pe[k]    = '0;
      if (reset) begin
        sb_clear(k);
        ovf_m[k]  = 1'b0;
        last_m[k] = '0;
      end else begin
        if (sz > 0) begin
          pop_m[k] = 1'b1;
          sb_pop(k, pe[k]);
        end
        for (int l = 0; l < NC; l++)
          if (cv[l] && !(filt && cid[l*5 +: 5] == 5'd0)) any = 1'b1;
        if (any) begin
          if ((DEPTH - sz) >= NC) begin
            for (int l = 0; l < NC; l++) begin
              if (cv[l] && !(filt && cid[l*5 +: 5] == 5'd0)) begin
                e.pc   = cpc[l*32 +: 32];
                e.id   = cid[l*5 +: 5];
                e.data = cdata[l*32 +: 32];
                e.wen  = (cid[l*5 +: 5] != 5'd0);
                sb_push(k, e);
              end
            end
          end else begin
            ovf_m[k] = 1'b1;
          end
        end
      end
    end
    @(posedge clk);
    #1;
    if (reset) known = 1'b1;
    for (int k = 0; k < 2; k++) begin
      if (pop_m[k]) last_m[k] = pe[k];
      chk($sformatf("wen[%0d]", k),   64'(wen[k]),   64'(pop_m[k] ? {4{pe[k].wen}} : 4'h0));
      chk($sformatf("pc[%0d]", k),    64'(wpc[k]),   64'(last_m[k].pc));
      chk($sformatf("wnum[%0d]", k),  64'(wnum[k]),  64'(last_m[k].id));
      chk($sformatf("wdata[%0d]", k), 64'(wdata[k]), 64'(last_m[k].data));
      chk($sformatf("ovf[%0d]", k),   64'(ovf[k]),   64'(ovf_m[k]));
    end
  endtask

  initial begin
    // Reset held with both lanes active: nothing may be accepted.
    reset = 1'b1;
    set_lane(0, 32'hBFC0_0100, 5'd1, 32'h11);
    set_lane(1, 32'hBFC0_0104, 5'd2, 32'h22);
    repeat (3) cycle();
    reset = 1'b0;
    idle();
    cycle();

    // Single lane commit, then drain and hold.
    set_lane(0, 32'hBFC0_0000, 5'd8, 32'h1234);
    cycle();
    idle();
    repeat (2) cycle();

    // Dual lane, lane 0 emitted first.
    set_lane(0, 32'hBFC0_0004, 5'd2, 32'd1);
    set_lane(1, 32'hBFC0_0008, 5'd3, 32'd2);
    cycle();
    idle();
    repeat (3) cycle();

    // R0 on lane 0: dropped by one instance, kept with wen=0 by the other.
    set_lane(0, 32'hBFC0_0010, 5'd0, 32'h77);
    set_lane(1, 32'hBFC0_0014, 5'd5, 32'h55);
    cycle();
    idle();
    repeat (3) cycle();

    // Backpressure: both lanes every cycle regardless of ready.
    for (int n = 0; n < 8; n++) begin
      set_lane(0, 32'hA000_0000 + 32'(n * 8),     5'(n * 2 + 1), 32'(n));
      set_lane(1, 32'hA000_0004 + 32'(n * 8),     5'(n * 2 + 2), ~32'(n));
      cycle();
    end
    idle();
    repeat (12) cycle();

    // Reset clears the sticky overflow.
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    cycle();

    // Twenty single commits with idle gaps, wrapping the pointers.
    for (int n = 1; n <= 20; n++) begin
      set_lane(0, 32'hBFC0_1000 + 32'(n * 4), 5'(n), 32'(n * 3));
      cycle();
      idle();
      cycle();
    end
    repeat (2) cycle();

    // Fill to level 5, then reset mid-operation.
    for (int n = 0; n < 4; n++) begin
      set_lane(0, 32'hC000_0000 + 32'(n * 8), 5'(n + 21), 32'(n + 100));
      set_lane(1, 32'hC000_0004 + 32'(n * 8), 5'(n + 25), 32'(n + 200));
      cycle();
    end
    idle();
    chk("level_before_reset", 64'(lvl[0]), 64'd5);
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/commit_trace_buffer.md
Name: commit_trace_buffer

Overview:
- Successor to the single-commit writeback debug port. Accepts up to NUM_COMMIT retired instructions per cycle from a multi-issue pipeline.
- Queues them in program order in a DEPTH-entry circular FIFO. Drains exactly one entry per cycle onto the golden-trace debug_wb_* interface.
- Sits between the core's commit stage and the top-level debug ports.
- Provides backpressure (ready), an occupancy level, and a sticky overflow flag.

Parameters:
- NUM_COMMIT, 2, commit lanes per cycle; lane 0 is oldest in program order.
- DEPTH, 8, FIFO entries; power of two, >= NUM_COMMIT (elaboration-time check).
- FILTER_R0, 1, 1 = drop commits with id==R0; 0 = enqueue them and emit with wen=0.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- commit_valid  in  NUM_COMMIT  per-lane commit strobe
- commit_pc  in  NUM_COMMIT x 32  per-lane retired pc (addr_t)
- commit_id  in  NUM_COMMIT x 5  per-lane destination register (regidx_t)
- commit_data  in  NUM_COMMIT x 32  per-lane written value (word_t)
- ready  out  1  free slots >= NUM_COMMIT
- level  out  $clog2(DEPTH+1)  current FIFO occupancy
- overflow  out  1  sticky: a valid commit was dropped
- debug_wb_pc  out  32  trace pc
- debug_wb_rf_wen  out  4  4'hF on a valid register write, else 4'h0
- debug_wb_rf_wnum  out  5  trace register number
- debug_wb_rf_wdata  out  32  trace write data

Behaviour:
- Reset (sync, high): head, tail and count = 0; overflow = 0; all debug_wb_* = 0. Reset has priority over push and pop in the same cycle. Reset mid-operation discards all queued entries.
- Lane qualification:
  - eff_valid[i] = commit_valid[i] && !(FILTER_R0 && commit_id[i]==0).
  - With FILTER_R0=0, an id==0 entry is stored with a wen flag of 0.
- Push:
  - When ready=1, all eff_valid lanes are written, compacted into consecutive slots starting at tail, in lane order (lane 0 first).
  - tail advances by popcount(eff_valid), mod DEPTH.
- Ready and drop:
  - ready = (DEPTH - count) >= NUM_COMMIT. Computed from the registered count only; ignores the same-cycle pop, so it is conservative.
  - If ready=0 and any eff_valid is set, all lanes that cycle are dropped, nothing is written, and overflow is set. overflow stays at 1 until reset.
- Pop:
  - Each cycle with count>0, the head entry is loaded into the debug_wb_* registers: pc, wnum=id, wdata=data, wen={4{stored_wen}}. head then advances mod DEPTH.
- Empty:
  - debug_wb_rf_wen = 0.
  - debug_wb_pc, wnum and wdata hold their last values.
- Latency: a commit accepted in cycle t reaches the debug_wb outputs in cycle t+1 at the earliest, when the FIFO was empty. Entries emerge one per cycle, strictly in order.
- Push and pop in the same cycle are legal. count_next = count + pushed - popped. An empty FIFO pushed in cycle t pops in cycle t+1; there is no same-cycle bypass.
- Wrap-around: head and tail are $clog2(DEPTH) bits and wrap naturally. Full vs empty is distinguished by count, not by pointer equality.
- Invariants (checked by assertions):
  - count <= DEPTH.
  - No pop when count==0.
  - level == count.

Decomposition:
- Shared defs package:
  - Reuse addr_t, word_t, regidx_t, strobe_t, R0.
  - Add commit_t struct {pc, id, data, wen}.
  - Add default constant NUM_COMMIT.
- Sub-module commit_compactor (combinational): takes eff_valid and lane payloads. Produces the compacted commit_t array and the push count.
- The top module holds the storage array, pointers, count, overflow and output registers.

Test Plan:
- Reset: hold reset 3 cycles with commit_valid=2'b11 -> outputs all 0, level=0, ready=1, overflow=0.
- Single lane: lane0 {pc=32'hBFC00000, id=8, data=32'h1234} at t -> t+1: wnum=8, wen=4'hF, wdata=32'h1234, pc=32'hBFC00000; t+2: wen=0 with pc/wnum/wdata held.
- Dual lane order: lane0 {32'hBFC00004, id=2, data=1}, lane1 {32'hBFC00008, id=3, data=2} at t -> t+1 emits id=2, t+2 emits id=3; level reads 2, then 1, then 0.
- R0 handling:
  - FILTER_R0=1, lane0 id=0 and lane1 id=5 -> only id=5 emitted at t+1.
  - FILTER_R0=0 -> t+1: pc of lane0 with wen=0; t+2: id=5 with wen=4'hF.
- Backpressure (DEPTH=8): drive 2'b11 every cycle, ignoring ready -> ready falls when level reaches 7. That cycle's commits are dropped, overflow=1 and stays 1. Accepted entries emerge gap-free and in order.
- Wrap and mid-op reset: 20 sequential single commits (id=1..20) interleaved with idle cycles -> ids emitted 1..20 in order across pointer wrap. Then fill to level=5 and assert reset -> next cycle level=0, wen=0, ready=1.
